// File: rtl/serv_rf_pkg.sv
// rtl/serv_rf_pkg.sv - shared sizing helpers and state type for the SERV dual-read register file
package serv_rf_pkg;

    localparam int GPR_COUNT = 32;
    localparam int XLEN      = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Words per port: all GPRs plus CSRs, each XLEN bits, sliced into width-bit words
    function automatic int rf_depth(input int width, input int csr_regs);
        return XLEN * (GPR_COUNT + csr_regs) / width;
    endfunction

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/serv_rf_rdport.sv
// rtl/serv_rf_rdport.sv - one registered read port with write-first bypass, x0 masking and parity check
module serv_rf_rdport #(
    parameter int width  = 8,
    parameter int aw     = 8,
    parameter int bypass = 1,
    parameter int parity = 1,
    parameter int zlsb   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ren,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic [width-1:0] i_mem_word,
    input  logic             i_mem_par,
    output logic [width-1:0] o_rdata,
    output logic             o_perr
);

    logic [width-1:0] rdata_q, rdata_d;
    logic             regzero_q, regzero_d;
    logic             perr_q, perr_d;
    logic             hit;

    // Next read state: load on enable, hold otherwise; parity error is a single-cycle pulse
    always_comb begin
        rdata_d   = rdata_q;
        regzero_d = regzero_q;
        perr_d    = 1'b0;
        hit       = (bypass != 0) && i_wen && (i_waddr == i_raddr);
        if (i_ren) begin
            rdata_d   = hit ? i_wdata : i_mem_word;
            // All address bits above the word-within-register slice zero means x0
            regzero_d = ((i_raddr >> zlsb) == '0);
            perr_d    = (parity != 0) && !hit && !regzero_d
                        && (i_mem_par != (^i_mem_word));
        end
    end

    // Read data, x0 flag and parity error registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q   <= '0;
            regzero_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            regzero_q <= regzero_d;
            perr_q    <= perr_d;
        end
    end

    assign o_rdata = rdata_q & ~{width{regzero_q}};
    assign o_perr  = perr_q;

endmodule

// File: rtl/serv_rf_ram_2r.sv
// rtl/serv_rf_ram_2r.sv - dual-read single-write SERV register file RAM with parity and post-reset clear
module serv_rf_ram_2r
    import serv_rf_pkg::*;
#(
    parameter int width          = 8,
    parameter int csr_regs       = 4,
    parameter int bypass         = 1,
    parameter int clear_on_reset = 1,
    parameter int parity         = 1,
    localparam int depth         = rf_depth(width, csr_regs),
    localparam int aw            = rf_aw(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic             i_wpar_flip,
    input  logic [aw-1:0]    i_raddr0,
    input  logic             i_ren0,
    input  logic [aw-1:0]    i_raddr1,
    input  logic             i_ren1,
    output logic [width-1:0] o_rdata0,
    output logic [width-1:0] o_rdata1,
    output logic             o_ready,
    output logic [1:0]       o_perr
);

    localparam int           ZLSB    = 5 - $clog2(width);
    localparam logic [aw-1:0] LAST   = aw'(depth - 1);
    localparam logic [aw:0]  DEPTH_W = (aw + 1)'(depth);

    rf_state_e        state_q, state_d;
    logic [aw-1:0]    cnt_q, cnt_d;
    logic             ready;
    logic             wen_act, ren0_act, ren1_act;
    logic             mem_we;
    logic [aw-1:0]    mem_waddr;
    logic [width-1:0] mem_wdata;
    logic             mem_wpar;

    logic [width-1:0] mem_q [depth];
    logic             par_q [depth];

    // Clear FSM state and sweep counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= (clear_on_reset != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one word per cycle; leave CLEAR once the last word is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = READY;
            end
        end
    end

    // Write-port steering: clear sweep owns the port until READY, then user traffic
    always_comb begin
        ready     = (state_q == READY);
        wen_act   = ready & i_wen;
        ren0_act  = ready & i_ren0;
        ren1_act  = ready & i_ren1;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wpar  = 1'b0;
        if (ready) begin
            mem_we    = i_wen;
            mem_waddr = i_waddr;
            mem_wdata = i_wdata;
            mem_wpar  = (parity != 0) ? ((^i_wdata) ^ i_wpar_flip) : 1'b0;
        end
    end

    // Storage array and parity bits; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
            par_q[mem_waddr] <= mem_wpar;
        end
    end

    // Simulation-only range check on addresses actually used
    always_ff @(posedge i_clk) begin
        if (i_rst_n && ready) begin
            assert (!(i_wen  && ({1'b0, i_waddr}  >= DEPTH_W)));
            assert (!(i_ren0 && ({1'b0, i_raddr0} >= DEPTH_W)));
            assert (!(i_ren1 && ({1'b0, i_raddr1} >= DEPTH_W)));
        end
    end

    serv_rf_rdport #(
        .width  (width),
        .aw     (aw),
        .bypass (bypass),
        .parity (parity),
        .zlsb   (ZLSB)
    ) u_rdport0 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ren      (ren0_act),
        .i_raddr    (i_raddr0),
        .i_wen      (wen_act),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata),
        .i_mem_word (mem_q[i_raddr0]),
        .i_mem_par  (par_q[i_raddr0]),
        .o_rdata    (o_rdata0),
        .o_perr     (o_perr[0])
    );

    serv_rf_rdport #(
        .width  (width),
        .aw     (aw),
        .bypass (bypass),
        .parity (parity),
        .zlsb   (ZLSB)
    ) u_rdport1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ren      (ren1_act),
        .i_raddr    (i_raddr1),
        .i_wen      (wen_act),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata),
        .i_mem_word (mem_q[i_raddr1]),
        .i_mem_par  (par_q[i_raddr1]),
        .o_rdata    (o_rdata1),
        .o_perr     (o_perr[1])
    );

    assign o_ready = ready;

endmodule

// File: tb/tb_serv_rf_ram_2r.sv
// tb/tb_serv_rf_ram_2r.sv - directed self-checking bench for serv_rf_ram_2r (bypass on and off)
module tb_serv_rf_ram_2r;

    logic       clk;
    logic       rst_n;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       wen;
    logic       wpar_flip;
    logic [7:0] raddr0;
    logic       ren0;
    logic [7:0] raddr1;
    logic       ren1;

    logic [7:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
    logic       ready_a, ready_b;
    logic [1:0] perr_a, perr_b;

    int checks = 0;
    int errors = 0;
    int n;

    serv_rf_ram_2r #(.bypass(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_wpar_flip (wpar_flip),
        .i_raddr0    (raddr0),
        .i_ren0      (ren0),
        .i_raddr1    (raddr1),
        .i_ren1      (ren1),
        .o_rdata0    (rdata0_a),
        .o_rdata1    (rdata1_a),
        .o_ready     (ready_a),
        .o_perr      (perr_a)
    );

    serv_rf_ram_2r #(.bypass(0)) dut_nb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_wpar_flip (wpar_flip),
        .i_raddr0    (raddr0),
        .i_ren0      (ren0),
        .i_raddr1    (raddr1),
        .i_ren1      (ren1),
        .o_rdata0    (rdata0_b),
        .o_rdata1    (rdata1_b),
        .o_ready     (ready_b),
        .o_perr      (perr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; wpar_flip = 1'b0; waddr = '0; wdata = '0;
        ren0 = 1'b0; raddr0 = '0; ren1 = 1'b0; raddr1 = '0;
        tick();
        tick();
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_rdata0", 32'(rdata0_a), 0);
        chk("rst_rdata1", 32'(rdata1_a), 0);
        chk("rst_perr", 32'(perr_a), 0);

        rst_n = 1'b1;
        n = 0;
        while (ready_a !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("clear_latency", n, 144);
        chk("clear_ready_nb", 32'(ready_b), 1);

        ren0 = 1'b1; raddr0 = 8'd4; ren1 = 1'b1; raddr1 = 8'd143;
        tick();
        chk("cleared_rd0", 32'(rdata0_a), 0);
        chk("cleared_rd1_last", 32'(rdata1_a), 0);
        chk("cleared_perr", 32'(perr_a), 0);

        ren0 = 1'b0; ren1 = 1'b0;
        wen = 1'b1; waddr = 8'd4; wdata = 8'hA5;
        tick();
        wen = 1'b0; ren0 = 1'b1; raddr0 = 8'd4;
        tick();
        chk("x1_rd0", 32'(rdata0_a), 32'hA5);
        chk("x1_perr", 32'(perr_a), 0);
        chk("x1_rd0_nb", 32'(rdata0_b), 32'hA5);
        ren0 = 1'b0;

        wen = 1'b1; waddr = 8'd0; wdata = 8'hFF;
        tick();
        waddr = 8'd1; wpar_flip = 1'b1;
        tick();
        wen = 1'b0; wpar_flip = 1'b0;
        for (int a = 0; a < 4; a++) begin
            ren1 = 1'b1; raddr1 = 8'(a);
            tick();
            chk("x0_rd1", 32'(rdata1_a), 0);
            chk("x0_perr", 32'(perr_a), 0);
        end
        raddr1 = 8'd4;
        tick();
        chk("x0_boundary_rd1", 32'(rdata1_a), 32'hA5);
        ren1 = 1'b0;

        wen = 1'b1; waddr = 8'd8; wdata = 8'h5A;
        tick();
        wdata = 8'h3C; ren0 = 1'b1; raddr0 = 8'd8; ren1 = 1'b1; raddr1 = 8'd8;
        tick();
        wen = 1'b0;
        chk("byp_rd0", 32'(rdata0_a), 32'h3C);
        chk("byp_rd1", 32'(rdata1_a), 32'h3C);
        chk("byp_perr", 32'(perr_a), 0);
        chk("nobyp_rd0", 32'(rdata0_b), 32'h5A);
        chk("nobyp_rd1", 32'(rdata1_b), 32'h5A);
        chk("nobyp_perr", 32'(perr_b), 0);
        tick();
        chk("after_byp_rd0_nb", 32'(rdata0_b), 32'h3C);
        chk("after_byp_rd1_nb", 32'(rdata1_b), 32'h3C);
        ren0 = 1'b0; ren1 = 1'b0;

        wen = 1'b1; waddr = 8'd12; wdata = 8'h11; wpar_flip = 1'b1;
        tick();
        wen = 1'b0; wpar_flip = 1'b0; ren0 = 1'b1; raddr0 = 8'd12;
        tick();
        chk("par_rd0", 32'(rdata0_a), 32'h11);
        chk("par_perr", 32'(perr_a), 32'h1);
        ren0 = 1'b0;
        tick();
        chk("par_pulse_end", 32'(perr_a), 0);
        chk("par_hold_rd0", 32'(rdata0_a), 32'h11);
        tick();
        chk("par_noren", 32'(perr_a), 0);
        ren1 = 1'b1; raddr1 = 8'd12;
        tick();
        chk("par_port1", 32'(perr_a), 32'h2);
        ren1 = 1'b0;

        wen = 1'b1; waddr = 8'd12; wdata = 8'h22; wpar_flip = 1'b1;
        ren0 = 1'b1; raddr0 = 8'd12;
        tick();
        wen = 1'b0; wpar_flip = 1'b0; ren0 = 1'b0;
        chk("bpar_rd0", 32'(rdata0_a), 32'h22);
        chk("bpar_perr", 32'(perr_a), 0);
        chk("bpar_rd0_nb", 32'(rdata0_b), 32'h11);
        chk("bpar_perr_nb", 32'(perr_b), 32'h1);

        rst_n = 1'b0;
        tick();
        chk("rst2_ready", 32'(ready_a), 0);
        chk("rst2_rd0", 32'(rdata0_a), 0);
        rst_n = 1'b1;
        ren0 = 1'b1; raddr0 = 8'd12;
        tick();
        tick();
        chk("clear_gate_rd0", 32'(rdata0_a), 0);
        chk("clear_gate_perr", 32'(perr_a), 0);
        ren0 = 1'b0;
        for (int i = 2; i < 50; i++) begin
            tick();
        end
        chk("midclear_ready", 32'(ready_a), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (ready_a !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (n == 100) begin
                wen = 1'b1; waddr = 8'd20; wdata = 8'h77;
            end else begin
                wen = 1'b0;
            end
        end
        wen = 1'b0;
        chk("restart_latency", n, 144);

        ren0 = 1'b1; raddr0 = 8'd20; ren1 = 1'b1; raddr1 = 8'd12;
        tick();
        chk("clear_write_absent", 32'(rdata0_a), 0);
        chk("recleared_rd1", 32'(rdata1_a), 0);
        chk("recleared_perr", 32'(perr_a), 0);
        ren0 = 1'b0; ren1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serv_rf_ram_2r.md
Name: serv_rf_ram_2r

Overview:
Next-generation SERV register-file RAM with two independent read ports, one write port, per-word parity and a hardware clear sequence after reset. Holds the 32 GPRs plus csr_regs CSRs, sliced into width-bit words. Sits between serv_rf_ram_if and the core; supports dual-issue bit-serial reads of rs1 and rs2. Adds write-first bypass and parity error reporting.

Parameters:
width, 8, word width in bits; power of two, 2..32
csr_regs, 4, CSR registers stored after the 32 GPRs
depth, 32*(32+csr_regs)/width, words per port (derived; do not override)
bypass, 1, 1 = a read that matches a same-cycle write returns i_wdata; 0 = returns old data
clear_on_reset, 1, 1 = zero every word after reset before accepting traffic
parity, 1, 1 = store and check one even-parity bit per word

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_waddr  in  $clog2(depth)  write word address
i_wdata  in  width  write data
i_wen  in  1  write enable
i_wpar_flip  in  1  test hook: inverts the stored parity bit on this write
i_raddr0  in  $clog2(depth)  read port 0 address
i_ren0  in  1  read port 0 enable
i_raddr1  in  $clog2(depth)  read port 1 address
i_ren1  in  1  read port 1 enable
o_rdata0  out  width  read port 0 data
o_rdata1  out  width  read port 1 data
o_ready  out  1  clear sequence finished; traffic accepted
o_perr  out  2  per-port parity error pulse

Behaviour:
- Reset (async on i_rst_n low): o_rdata0/1=0, o_perr=0, clear counter=0. State=CLEAR if clear_on_reset, else READY. o_ready=0 in CLEAR, 1 in READY. Memory contents are not reset asynchronously.
- CLEAR: each cycle writes 0 (with parity 0) to word clear counter, then increments the counter. After word depth-1 is written, state goes to READY. o_ready rises on the next edge, exactly depth cycles after reset release. During CLEAR: i_wen is ignored, o_rdata0/1=0, o_perr=0.
- Reset asserted mid-CLEAR: the counter returns to 0 and the sweep restarts from word 0.
- READY write: on an edge with i_wen=1, memory[i_waddr]<=i_wdata and par[i_waddr]<=^i_wdata ^ i_wpar_flip (when parity=1).
- READY read, per port n: 1-cycle latency. On an edge with i_renN=1:
  - rdata register <= memory[i_raddrN], or i_wdata when bypass=1, i_wen=1 and i_waddr==i_raddrN.
  - regzeroN <= (i_raddrN[$clog2(depth)-1 : 5-$clog2(width)] == 0).
- o_rdataN = rdata & ~{width{regzeroN}}, so x0 always reads 0.
- i_renN=0: rdata and regzeroN hold their values, so o_rdataN holds.
- Parity: o_perr[n] is 1 for exactly the cycle in which the read data is presented, when all of the following hold: parity=1, the read was enabled, it was not bypassed, it was not an x0 read, and the stored parity does not equal ^stored word. Otherwise o_perr[n] is 0.
- Both ports reading the same address is legal; the ports return identical data.
- Out-of-range addresses (>= depth) are undefined; an assertion flags them in simulation.

Decomposition:
- Package serv_rf_pkg holds:
  - function rf_depth(width, csr_regs)
  - function rf_aw(depth)
  - localparam for GPR count 32
  - state enum {CLEAR, READY}
- Natural sub-module: serv_rf_rdport, instantiated once per port. It contains the bypass mux, rdata/regzero/parity registers and the error compare. The top level holds the memory array, parity array and clear FSM.

Test Plan:
- width=8, clear_on_reset=1: release reset -> o_ready=0 for 144 cycles, then 1. All reads return 0 afterwards.
- Write 0xA5 to addr 4 (x1 word 0), read port0 addr 4 next cycle -> o_rdata0=0xA5 one cycle later, o_perr=0.
- Write 0xFF to addr 0 (x0); read addr 0..3 on port1 -> o_rdata1=0x00 every read.
- Same cycle: write 0x3C to addr 8 with both ports reading addr 8:
  - bypass=1 -> both ports return 0x3C
  - bypass=0 -> both ports return the previous value
- Write 0x11 to addr 12 with i_wpar_flip=1, then read it on port0 -> o_rdata0=0x11, o_perr=2'b01 for one cycle. The same read with i_ren0=0 gives no pulse.
- Pull i_rst_n low at clear count 50, release -> o_ready rises 144 cycles after release. A write issued during CLEAR is absent afterwards (reads 0).
